// File: rtl/match_token_gen.sv
// match_token_gen: turns per-position best-match results into literal/match tokens,
// skipping positions covered by an emitted match and marking end of block.
module match_token_gen #(
  parameter int MIN_LEN = 3,
  parameter int MAX_LEN = 16,
  parameter int DIST_W  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_len,
  input  logic [4:0]        in_idx,
  input  logic [DIST_W-1:0] in_dist,
  input  logic [7:0]        in_lit,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_match,
  output logic [4:0]        out_len,
  output logic [DIST_W-1:0] out_dist,
  output logic [4:0]        out_idx,
  output logic [7:0]        out_lit,
  output logic              out_last,
  output logic              out_eob,
  output logic [31:0]       lit_cnt,
  output logic [31:0]       match_cnt
);
  typedef enum logic {EMIT, SKIP} state_t;
  localparam logic [4:0] LMIN = 5'(MIN_LEN);
  localparam logic [4:0] LMAX = 5'(MAX_LEN);
  state_t r_state, w_state_nxt;
  logic [3:0] r_skip, w_skip_nxt;
  logic r_pend, w_pend_nxt;
  logic w_free, w_acc, w_emit, w_match, w_load_eob;
  logic [4:0] w_len;
  assign w_free = !out_valid || out_ready;
  assign in_ready = r_pend ? 1'b0 : (r_state == SKIP ? 1'b1 : w_free);
  assign w_acc = in_valid && in_ready;
  assign w_len = in_len > LMAX ? LMAX : in_len;
  assign w_match = w_len >= LMIN && in_dist != '0;
  assign w_emit = w_acc && r_state == EMIT;
  // An end-of-block seen while skipping waits here if the output register is stalled
  assign w_load_eob = w_free && (r_pend || (w_acc && r_state == SKIP && in_last));
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt = r_skip;
    w_pend_nxt = r_pend && !w_free;
    if (w_emit && w_match && !in_last && w_len > 5'd1) begin
      w_state_nxt = SKIP;
      w_skip_nxt = 4'(w_len - 5'd1);
    end
    if (w_acc && r_state == SKIP) begin
      w_state_nxt = (in_last || r_skip == 4'd1) ? EMIT : SKIP;
      w_skip_nxt = in_last ? 4'd0 : r_skip - 4'd1;
      w_pend_nxt = in_last && !w_free;
    end
  end
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= EMIT;
      r_skip <= '0;
      r_pend <= 1'b0;
      out_valid <= 1'b0;
      out_is_match <= 1'b0;
      out_len <= '0;
      out_dist <= '0;
      out_idx <= '0;
      out_lit <= '0;
      out_last <= 1'b0;
      out_eob <= 1'b0;
      lit_cnt <= '0;
      match_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_skip <= w_skip_nxt;
      r_pend <= w_pend_nxt;
      if (w_emit) begin
        out_valid <= 1'b1;
        out_is_match <= w_match;
        out_len <= w_match ? w_len : 5'd0;
        out_dist <= w_match ? in_dist : '0;
        out_idx <= w_match ? in_idx : 5'd0;
        out_lit <= in_lit;
        out_last <= in_last;
        out_eob <= 1'b0;
      end else if (w_load_eob) begin
        out_valid <= 1'b1;
        out_is_match <= 1'b0;
        out_len <= '0;
        out_dist <= '0;
        out_idx <= '0;
        out_lit <= '0;
        out_last <= 1'b1;
        out_eob <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && !out_eob) begin
        if (out_is_match) match_cnt <= match_cnt + 32'd1;
        else lit_cnt <= lit_cnt + 32'd1;
      end
    end
  end
endmodule
